fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage and drives its 32-bit Instruction input.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents one per cycle to decode.
- Honours the decode Stall and redirects on taken branches; a bubble is opcode 0000 (NOP) = 32'h0.

Parameters:
ADDR_W, 20, PC/word-address width; matches the 20-bit immediate field.
DEPTH, 2, prefetch FIFO entries; power of 2, >=2.
RESET_PC, 0, PC value loaded at reset.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-low reset.
Stall  input  1  from decode; hold the current Instruction.
BrTaken  input  1  one-cycle pulse; redirect fetch to BrTarget.
BrTarget  input  ADDR_W  branch destination word address.
ImemReq  output  1  fetch request to instruction memory.
ImemAddr  output  ADDR_W  fetch word address.
ImemAck  input  1  memory returns ImemData this cycle.
ImemData  input  32  fetched instruction word.
Instruction  output  32  instruction to decode; 32'h0 when no valid word.
InstrValid  output  1  Instruction holds a real fetched word.
PcOut  output  ADDR_W  address of the word on Instruction.
StallCount  output  16  present only with FETCH_STALL_CNT_EN.

Behaviour:
- Reset (rst==0 at posedge):
  - PC=RESET_PC; FIFO empty; Discard=0; state=IDLE.
  - ImemReq=0, ImemAddr=RESET_PC, Instruction=32'h0, InstrValid=0, PcOut=RESET_PC, StallCount=0.
  - Reset mid-request drops the outstanding request; an ack arriving afterwards is ignored.
- Handshake:
  - At most one outstanding request.
  - While ImemReq=1, ImemAddr is held stable until the cycle ImemAck=1.
  - An ack may arrive in the first request cycle or any later cycle. ImemAck with ImemReq=0 is ignored.
- State machine:
  - IDLE: next cycle -> REQ.
  - REQ: if free FIFO slots > 0, assert ImemReq with ImemAddr=PC and go to WAIT; otherwise stay in REQ with ImemReq=0.
  - WAIT: ImemReq=1. On ack:
    - if Discard=0, push {PC,ImemData} and set PC<=PC+1 (wraps 2^ADDR_W-1 -> 0);
    - if Discard=1, drop the data and clear Discard;
    - ImemReq deasserts the cycle after the ack; -> REQ.
- Output register (posedge):
  - Stall=1: Instruction, PcOut and InstrValid hold.
  - Stall=0 and FIFO non-empty: pop head; Instruction<=data, PcOut<=addr, InstrValid<=1.
  - Stall=0 and FIFO empty: Instruction<=32'h0, InstrValid<=0, PcOut holds.
  - A word pushed this cycle is not popped until the next cycle (1-cycle minimum ack-to-Instruction latency).
- Redirect (BrTaken=1), highest priority, overrides Stall:
  - PC<=BrTarget; FIFO flushed; Instruction<=32'h0; InstrValid<=0.
  - In WAIT without an ack this cycle: Discard<=1 and stay in WAIT.
  - In WAIT with an ack this cycle: drop the data, Discard stays 0, -> REQ.
  - In REQ: the next request uses BrTarget.
- FIFO full: no request issued; PC unchanged. FIFO empty: bubbles as above.
- Free slots = DEPTH - count - (outstanding ? 1 : 0); a request is issued only if free slots > 0.

Optional Feature:
- FETCH_STALL_CNT_EN defined:
  - StallCount port exists.
  - Increments by 1 each cycle with Stall=1 and rst=1; saturates at 16'hFFFF.
  - Cleared only by reset.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, 1-cycle-latency memory returning word = 32'h9000_0000|addr -> ImemAddr 0,1,2,...; first InstrValid=1 with Instruction=32'h9000_0000, PcOut=0; then one word per cycle in order.
- Stall=1 for 4 cycles at PcOut=3 -> Instruction/PcOut hold at addr 3; no request while FIFO full (2 entries); after release, addrs 4,5 appear with no gap or duplicate.
- BrTaken with BrTarget=20'h00100 while a request is outstanding and the ack comes 3 cycles later -> acked word dropped; next ImemAddr=20'h00100; Instruction=0 until that word arrives.
- BrTaken and ImemAck in the same cycle -> data dropped, Discard stays 0, next request to BrTarget on the following cycle.
- PC at 20'hFFFFF -> next ImemAddr=20'h00000.
- rst=0 mid-WAIT, ack arrives after reset -> ignored; fetch restarts at RESET_PC; with FETCH_STALL_CNT_EN, 5 stall cycles -> StallCount=5, and StallCount=0 after reset.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem req/ack, prefetch FIFO, registered decode port (>=1 cycle ack-to-Instruction).
// Stall holds the output and no request issues without a free FIFO slot; FETCH_STALL_CNT_EN adds StallCount.

// Small FIFO with synchronous flush; caller never pushes into a full FIFO or pops an empty one.
module fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

module fetch_stage #(
    parameter int                ADDR_W   = 20,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Stall,
    input  logic              BrTaken,
    input  logic [ADDR_W-1:0] BrTarget,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemAck,
    input  logic [31:0]       ImemData,
    output logic [31:0]       Instruction,
    output logic              InstrValid,
    output logic [ADDR_W-1:0] PcOut
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       StallCount
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]           state;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    req_addr;
    logic                 discard;
    logic [CNT_W-1:0]     fifo_count;
    logic [ADDR_W+31:0]   head_dat;
    logic                 outstanding;
    logic                 slot_free;
    logic                 push;
    logic                 pop;

    assign outstanding = (state == S_WAIT);
    // The in-flight request already owns a slot, so it counts against free space.
    assign slot_free   = (fifo_count + {{(CNT_W-1){1'b0}}, outstanding}) < CNT_W'(DEPTH);
    assign push        = outstanding && ImemAck && !discard && !BrTaken;
    assign pop         = !BrTaken && !Stall && (fifo_count != '0);

    fetch_fifo #(
        .W     (ADDR_W + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (BrTaken),
        .push     (push),
        .push_dat ({req_addr, ImemData}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (!BrTaken && slot_free) begin
                        req_addr <= pc;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ImemAck) begin
                        state   <= S_REQ;
                        discard <= 1'b0;
                        if (push) pc <= pc + 1'b1;
                    end else if (BrTaken) begin
                        // Address must stay stable until the ack, so the stale word is dropped on arrival.
                        discard <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (BrTaken) pc <= BrTarget;
        end
    end

    assign ImemReq  = outstanding;
    assign ImemAddr = outstanding ? req_addr : pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            Instruction <= 32'h0;
            InstrValid  <= 1'b0;
            PcOut       <= RESET_PC;
        end else if (BrTaken) begin
            Instruction <= 32'h0;
            InstrValid  <= 1'b0;
        end else if (!Stall) begin
            if (fifo_count != '0) begin
                Instruction <= head_dat[31:0];
                PcOut       <= head_dat[ADDR_W+31:32];
                InstrValid  <= 1'b1;
            end else begin
                Instruction <= 32'h0;
                InstrValid  <= 1'b0;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            StallCount <= 16'h0;
        end else if (Stall && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random-latency memory, expected fetch stream kept as an address queue, decoupled monitor.
module tb_fetch_stage;
    localparam int              AW       = 20;
    localparam logic [AW-1:0]   RESET_PC = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          Stall;
    logic          BrTaken;
    logic [AW-1:0] BrTarget;
    logic          ImemReq;
    logic [AW-1:0] ImemAddr;
    logic          ImemAck;
    logic [31:0]   ImemData;
    logic [31:0]   Instruction;
    logic          InstrValid;
    logic [AW-1:0] PcOut;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0]   StallCount;
`endif

    int total = 0;
    int bad   = 0;

    int lat_min   = 0;
    int lat_max   = 0;
    bit stale_ack = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(
        .ADDR_W   (AW),
        .DEPTH    (2),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Stall       (Stall),
        .BrTaken     (BrTaken),
        .BrTarget    (BrTarget),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemAck     (ImemAck),
        .ImemData    (ImemData),
        .Instruction (Instruction),
        .InstrValid  (InstrValid),
        .PcOut       (PcOut)
`ifdef FETCH_STALL_CNT_EN
        ,
        .StallCount  (StallCount)
`endif
    );

    task automatic check(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return 32'h9000_0000 | {12'h0, a};
    endfunction

    // Memory: acks lat_min..lat_max cycles after a request is first seen.
    initial begin
        int cnt;
        cnt = -1;
        ImemAck  = 1'b0;
        ImemData = 32'h0;
        forever begin
            @(negedge clk);
            ImemAck = 1'b0;
            if (stale_ack) begin
                ImemAck  = 1'b1;
                ImemData = 32'hDEAD_BEEF;
            end else if (ImemReq) begin
                if (cnt < 0) cnt = $urandom_range(lat_min, lat_max);
                if (cnt == 0) begin
                    ImemAck  = 1'b1;
                    ImemData = word_of(ImemAddr);
                    cnt      = -1;
                end else begin
                    cnt--;
                end
            end else begin
                cnt = -1;
            end
        end
    end

    // Reference: a program fetched sequentially from the last redirect/reset point.
    logic [AW-1:0] expq[$];
    logic [AW-1:0] tail;

    task automatic restart(input logic [AW-1:0] a);
        expq.delete();
        tail = a;
        while (expq.size() < 8) begin
            expq.push_back(tail);
            tail = tail + 1'b1;
        end
    endtask

    initial begin
        logic          e_rst, e_stall, e_br;
        logic [AW-1:0] e_tgt;
        logic [31:0]   p_instr;
        logic [AW-1:0] p_pc, p_addr, want_addr, a;
        logic          p_valid, p_req, p_ack, want, new_req;
        int            sc;
        p_instr = '0; p_pc = '0; p_addr = '0; p_valid = 0; p_req = 0; p_ack = 0;
        want = 0; want_addr = '0; sc = 0;
        forever begin
            @(posedge clk);
            e_rst = rst; e_stall = Stall; e_br = BrTaken; e_tgt = BrTarget;
            if (!e_rst) begin
                restart(RESET_PC);
                want = 1; want_addr = RESET_PC; sc = 0;
            end else begin
                if (e_br) begin
                    restart(e_tgt);
                    want = 1; want_addr = e_tgt;
                end
                if (e_stall && sc < 65535) sc++;
            end
            @(negedge clk);
            #2;
            if (!e_rst) begin
                check("reset_req", ImemReq == 1'b0, 64'(ImemReq), 64'd0);
                check("reset_addr", ImemAddr == RESET_PC, 64'(ImemAddr), 64'(RESET_PC));
                check("reset_out", Instruction == 32'h0 && !InstrValid && PcOut == RESET_PC,
                      {11'h0, InstrValid, PcOut, Instruction}, {32'h0, RESET_PC, 32'h0});
            end else if (e_br) begin
                check("redirect_flush", Instruction == 32'h0 && !InstrValid,
                      {31'h0, InstrValid, Instruction}, 64'd0);
            end else if (e_stall) begin
                check("stall_hold", Instruction == p_instr && PcOut == p_pc && InstrValid == p_valid,
                      {11'h0, InstrValid, PcOut, Instruction}, {11'h0, p_valid, p_pc, p_instr});
            end else if (InstrValid) begin
                if (expq.size() == 0) begin
                    check("stream_empty", 1'b0, 64'(PcOut), 64'd0);
                end else begin
                    a = expq.pop_front();
                    check("stream", PcOut == a && Instruction == word_of(a),
                          {PcOut, Instruction}, {a, word_of(a)});
                    while (expq.size() < 8) begin
                        expq.push_back(tail);
                        tail = tail + 1'b1;
                    end
                end
            end
            if (!InstrValid) check("bubble_zero", Instruction == 32'h0, 64'(Instruction), 64'd0);
            new_req = ImemReq && (!p_req || p_ack);
            if (ImemReq && p_req && !p_ack)
                check("addr_stable", ImemAddr == p_addr, 64'(ImemAddr), 64'(p_addr));
            if (want && new_req) begin
                check("req_target", ImemAddr == want_addr, 64'(ImemAddr), 64'(want_addr));
                want = 0;
            end
`ifdef FETCH_STALL_CNT_EN
            check("stall_count", StallCount == 16'(sc), 64'(StallCount), 64'(sc));
`endif
            p_instr = Instruction; p_pc = PcOut; p_valid = InstrValid;
            p_req = ImemReq; p_ack = ImemAck; p_addr = ImemAddr;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_new_req(input string name);
        int  n;
        logic was;
        n = 0;
        was = ImemReq;
        cyc(1);
        while (!(ImemReq && !was) && n < 100) begin
            was = ImemReq;
            cyc(1);
            n++;
        end
        check(name, n < 100, 64'(n), 64'd100);
    endtask

    initial begin
        int n;
        rst = 1'b0; Stall = 1'b0; BrTaken = 1'b0; BrTarget = '0;
        lat_min = 0; lat_max = 0;
        cyc(3);
        rst = 1'b1;

        // In-order stream, then a 4-cycle stall at PcOut=3.
        n = 0;
        while (!(InstrValid && PcOut == 20'd3) && n < 200) begin cyc(1); n++; end
        check("wait_pc3", n < 200, 64'(n), 64'd200);
        Stall = 1'b1;
        cyc(4);
        Stall = 1'b0;
        cyc(6);

        // Long stall: FIFO fills and requests stop.
        Stall = 1'b1;
        cyc(8);
        for (int i = 0; i < 4; i++) begin
            check("full_no_req", ImemReq == 1'b0, 64'(ImemReq), 64'd0);
            cyc(1);
        end
        Stall = 1'b0;
        cyc(10);

        // Redirect while a 3-cycle-latency request is in flight.
        lat_min = 3; lat_max = 3;
        wait_new_req("wait_req_br");
        BrTaken = 1'b1; BrTarget = 20'h00100;
        cyc(1);
        BrTaken = 1'b0;
        cyc(20);

        // Redirect in the same cycle as an ack.
        lat_min = 0; lat_max = 0;
        n = 0;
        while (!ImemAck && n < 100) begin cyc(1); n++; end
        check("wait_ack", n < 100, 64'(n), 64'd100);
        BrTaken = 1'b1; BrTarget = 20'h00200;
        cyc(1);
        BrTaken = 1'b0;
        cyc(15);

        // PC wraps past the top of the address space.
        BrTaken = 1'b1; BrTarget = 20'hFFFFE;
        cyc(1);
        BrTaken = 1'b0;
        cyc(20);

        // Random traffic.
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            Stall    = ($urandom_range(0, 9) < 3);
            BrTaken  = ($urandom_range(0, 24) == 0);
            BrTarget = AW'($urandom);
            cyc(1);
        end
        Stall = 1'b0; BrTaken = 1'b0;
        cyc(10);

        // Reset mid-request with a late ack, then five stall cycles.
        lat_min = 5; lat_max = 5;
        wait_new_req("wait_req_rst");
        rst = 1'b0;
        cyc(1);
        rst = 1'b1; stale_ack = 1'b1;
        cyc(1);
        stale_ack = 1'b0;
        lat_min = 0; lat_max = 2;
        Stall = 1'b1;
        cyc(5);
        Stall = 1'b0;
        cyc(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
